// File: rtl/proj.sv
// proj: direct-form-I IIR filter, up to third order, one signed 16-bit
// sample per clock. The coefficients are signed Q4.12 and are read
// combinationally every cycle. The feedback order can be selected at run time.
module proj (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic [15:0] b0,
  input  logic [15:0] b1,
  input  logic [15:0] b2,
  input  logic [15:0] a1,
  input  logic [15:0] a2,
  input  logic [15:0] a3,
  input  logic [3:0]  order,
  output logic [15:0] data_out
);

  localparam int NTAPS = 6;
  localparam int NFF   = 3;

  // History registers. y1_q is the registered output y[n-1].
  logic signed [15:0] x1_q, x1_d;
  logic signed [15:0] x2_q, x2_d;
  logic signed [15:0] y1_q, y1_d;
  logic signed [15:0] y2_q, y2_d;
  logic signed [15:0] y3_q, y3_d;

  // Tap operands. Taps 0..2 are feedforward and taps 3..5 are feedback.
  // An inactive feedback tap has its coefficient forced to zero, so its
  // product is exactly 0. Its history still shifts.
  logic signed [15:0] coef [NTAPS];
  logic signed [15:0] samp [NTAPS];
  logic signed [31:0] prod [NTAPS];

  logic signed [35:0] acc;
  logic signed [35:0] shifted;
  logic signed [15:0] y_sat;

  assign coef[0] = b0;
  assign coef[1] = b1;
  assign coef[2] = b2;
  assign coef[3] = (order >= 4'd1) ? a1 : 16'sd0;
  assign coef[4] = (order >= 4'd2) ? a2 : 16'sd0;
  assign coef[5] = (order >= 4'd3) ? a3 : 16'sd0;

  assign samp[0] = data_in;
  assign samp[1] = x1_q;
  assign samp[2] = x2_q;
  assign samp[3] = y1_q;
  assign samp[4] = y2_q;
  assign samp[5] = y3_q;

  // One full-precision 16x16 signed multiplier per tap.
  for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
    assign prod[gi] = coef[gi] * samp[gi];
  end

  // Accumulate in 36 bits. This width cannot overflow for six products.
  // Then floor-shift by 12 (Q4.12 -> integer) and saturate to 16 bits.
  always_comb begin
    acc = '0;
    for (int i = 0; i < NFF; i++) begin
      acc = acc + 36'(prod[i]);
    end
    for (int i = NFF; i < NTAPS; i++) begin
      acc = acc - 36'(prod[i]);
    end
    shifted = acc >>> 12;
    if (shifted > 36'sd32767) begin
      y_sat = 16'sh7FFF;
    end else if (shifted < -36'sd32768) begin
      y_sat = 16'sh8000;
    end else begin
      y_sat = shifted[15:0];
    end
  end

  // Next-state values for the histories. Both chains shift every cycle.
  always_comb begin
    x1_d = data_in;
    x2_d = x1_q;
    y1_d = y_sat;
    y2_d = y1_q;
    y3_d = y2_q;
  end

  // State registers with asynchronous clear of all history and the output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x1_q <= '0;
      x2_q <= '0;
      y1_q <= '0;
      y2_q <= '0;
      y3_q <= '0;
    end else begin
      x1_q <= x1_d;
      x2_q <= x2_d;
      y1_q <= y1_d;
      y2_q <= y2_d;
      y3_q <= y3_d;
    end
  end

  assign data_out = y1_q;

endmodule

// File: tb/tb_proj.sv
// tb_proj: scoreboard bench for the proj IIR filter. The stimulus pushes the
// expected output for each issued sample, and a negedge monitor pops and
// compares it. The reference model evaluates the difference equation with
// 64-bit integer arithmetic and explicit floor division.
module tb_proj;

  logic        clk;
  logic        reset;
  logic signed [15:0] data_in;
  logic signed [15:0] b0, b1, b2, a1, a2, a3;
  logic [3:0]  order;
  logic [15:0] data_out;

  proj dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .b0       (b0),
    .b1       (b1),
    .b2       (b2),
    .a1       (a1),
    .a2       (a2),
    .a3       (a3),
    .order    (order),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int    due;
    int    val;
    string name;
  } exp_t;
  exp_t sb[$];

  // Reference model state: past inputs and past outputs as plain integers.
  longint xh [2];
  longint yh [3];

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: data_out=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_clear();
    xh[0] = 0; xh[1] = 0;
    yh[0] = 0; yh[1] = 0; yh[2] = 0;
  endfunction

  // One filter step computed straight from the difference equation.
  function automatic int model_step(input longint x);
    longint acc, q;
    int nfb;
    nfb = (order >= 3) ? 3 : int'(order);
    acc = longint'(b0) * x + longint'(b1) * xh[0] + longint'(b2) * xh[1];
    if (nfb >= 1) acc -= longint'(a1) * yh[0];
    if (nfb >= 2) acc -= longint'(a2) * yh[1];
    if (nfb >= 3) acc -= longint'(a3) * yh[2];
    q = acc / 4096;
    if ((acc % 4096 != 0) && (acc < 0)) q -= 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    xh[1] = xh[0]; xh[0] = x;
    yh[2] = yh[1]; yh[1] = yh[0]; yh[0] = q;
    return int'(q);
  endfunction

  // Issue one sample. If use_req is set, the literal required value is
  // scored instead of the model value. The model still advances.
  task automatic step(input int x, input bit use_req, input int req, input string name);
    exp_t e;
    int m;
    data_in = 16'(x);
    m = model_step(longint'(data_in));
    e.due  = cyc + 1;
    e.val  = use_req ? req : m;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_coefs(input int cb0, input int cb1, input int cb2,
                           input int ca1, input int ca2, input int ca3, input int ord);
    b0 = 16'(cb0); b1 = 16'(cb1); b2 = 16'(cb2);
    a1 = 16'(ca1); a2 = 16'(ca2); a3 = 16'(ca3);
    order = 4'(ord);
  endtask

  // Assert reset between edges, check the immediate clear, hold it, then release.
  task automatic do_reset();
    @(negedge clk);
    #1;
    data_in = 16'($urandom);
    reset = 1'b0;
    #1;
    check("reset_async", int'($signed(data_out)), 0);
    model_clear();
    repeat (2) begin
      @(negedge clk);
      check("reset_hold", int'($signed(data_out)), 0);
    end
    reset = 1'b1;
  endtask

  // Monitor: score every expected value whose output edge has occurred.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, int'($signed(data_out)), e.val);
    end
  end

  function automatic int rnd_coef();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 65535)) - 32768;
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  initial begin
    reset = 1'b0;
    data_in = '0;
    set_coefs(0, 0, 0, 0, 0, 0, 0);
    model_clear();
    #1;
    check("reset_state", int'($signed(data_out)), 0);
    repeat (2) @(negedge clk);
    check("reset_state_hold", int'($signed(data_out)), 0);
    reset = 1'b1;

    // Pass-through.
    set_coefs('h1000, 0, 0, 0, 0, 0, 0);
    step(5, 1, 5, "pass_5");
    step(-7, 1, -7, "pass_m7");
    step(300, 1, 300, "pass_300");

    // FIR impulse.
    do_reset();
    set_coefs('h1000, 'h1000, 'h1000, 0, 0, 0, 0);
    step(100, 1, 100, "fir_imp0");
    step(0, 1, 100, "fir_imp1");
    step(0, 1, 100, "fir_imp2");
    step(0, 1, 0, "fir_imp3");
    step(0, 1, 0, "fir_imp4");

    // First-order feedback, order 1.
    do_reset();
    set_coefs('h1000, 0, 0, 'hF800, 0, 0, 1);
    step(1000, 1, 1000, "iir1_0");
    step(0, 1, 500, "iir1_1");
    step(0, 1, 250, "iir1_2");
    step(0, 1, 125, "iir1_3");
    step(0, 1, 62, "iir1_4");
    step(0, 1, 31, "iir1_5");

    // Same coefficients, feedback disabled.
    do_reset();
    set_coefs('h1000, 0, 0, 'hF800, 0, 0, 0);
    step(1000, 1, 1000, "ord0_0");
    step(0, 1, 0, "ord0_1");

    // Arithmetic edges: floor truncation and saturation.
    do_reset();
    set_coefs('h0800, 0, 0, 0, 0, 0, 0);
    step(-3, 1, -2, "floor_m3");
    set_coefs('h4000, 0, 0, 0, 0, 0, 0);
    step(20000, 1, 32767, "sat_pos");
    step(-20000, 1, -32768, "sat_neg");

    // Reset mid-stream, then a fresh start.
    do_reset();
    set_coefs('h1000, 0, 0, 'hF800, 0, 0, 1);
    step(1000, 1, 1000, "rst_run0");
    step(0, 1, 500, "rst_run1");
    do_reset();
    step(0, 1, 0, "rst_quiet0");
    step(0, 1, 0, "rst_quiet1");
    step(1000, 1, 1000, "rst_new0");
    step(0, 1, 500, "rst_new1");
    step(0, 1, 250, "rst_new2");

    // Randomized run with periodic coefficient/order changes, held samples
    // and occasional resets. The model decides every expected value.
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) begin
        set_coefs(rnd_coef(), rnd_coef(), rnd_coef(), rnd_coef(), rnd_coef(), rnd_coef(),
                  int'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 299) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) begin
        int x = int'($urandom_range(0, 65535)) - 32768;
        int k = int'($urandom_range(1, 3));
        for (int j = 0; j < k; j++) step(x, 0, 0, "rand_hold");
      end else begin
        step(int'($urandom_range(0, 65535)) - 32768, 0, 0, "rand");
      end
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected outputs never scored, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
